// File: rtl/branch_update_queue_pkg.sv
// Shared widths and retire classification for the branch update queue.
package branch_update_queue_pkg;

    localparam int BRA_ADDR_WIDTH = 6;
    localparam int ROB_TAG_WIDTH  = 3;
    localparam int BUQ_DEPTH      = 8;

    typedef enum logic [1:0] {
        RET_NONE       = 2'd0,
        RET_OK         = 2'd1,
        RET_MISPREDICT = 2'd2
    } retire_kind_e;

    function automatic retire_kind_e classify_retire(input logic head_ready,
                                                     input logic pred,
                                                     input logic taken);
        if (!head_ready)
            return RET_NONE;
        else if (pred != taken)
            return RET_MISPREDICT;
        else
            return RET_OK;
    endfunction

endpackage

// File: rtl/branch_update_queue_tag.sv
// Combinational resolve-tag lookup: one-hot hit vector over valid, unresolved entries.
module buq_tag_match
    import branch_update_queue_pkg::*;
#(
    parameter int DEPTH = BUQ_DEPTH,
    parameter int TAG_W = ROB_TAG_WIDTH
) (
    input  logic                        alu_valid,
    input  logic [TAG_W-1:0]            alu_tag,
    input  logic [DEPTH-1:0][TAG_W-1:0] tags,
    input  logic [DEPTH-1:0]            valid,
    input  logic [DEPTH-1:0]            resolved,
    output logic [DEPTH-1:0]            match
);

    // Tags are unique in the queue, so at most one bit can be set.
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++)
            match[i] = alu_valid && valid[i] && !resolved[i] && (tags[i] == alu_tag);
    end

endmodule

// File: rtl/branch_update_queue.sv
// In-order retirement queue for predicted branches; trains the predictor and squashes on mispredict.
module branch_update_queue
    import branch_update_queue_pkg::*;
#(
    parameter int ADDR_W = BRA_ADDR_WIDTH,
    parameter int TAG_W  = ROB_TAG_WIDTH,
    parameter int DEPTH  = BUQ_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    input  logic [ADDR_W-1:0] dec_addr,
    input  logic              dec_prediction,
    input  logic [TAG_W-1:0]  dec_tag,
    output logic              dec_ready,
    input  logic              alu_valid,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic              alu_taken,
    output logic              brp_update,
    output logic [ADDR_W-1:0] rob_addr,
    output logic              rob_prediction,
    output logic              mispredict,
    output logic [TAG_W-1:0]  mispredict_tag
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]             head;
    logic [PTR_W-1:0]             tail;
    logic [DEPTH-1:0]             valid;
    logic [DEPTH-1:0]             resolved;
    logic [DEPTH-1:0]             taken;
    logic [DEPTH-1:0]             pred;
    logic [DEPTH-1:0][ADDR_W-1:0] addr;
    logic [DEPTH-1:0][TAG_W-1:0]  tags;
    logic [DEPTH-1:0]             match;

    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic             full;
    logic             enqueue;
    retire_kind_e     retire_kind;
    logic             retire;
    logic             squash;

    assign head_idx  = head[IDX_W-1:0];
    assign tail_idx  = tail[IDX_W-1:0];
    assign full      = (head_idx == tail_idx) && (head[PTR_W-1] != tail[PTR_W-1]);
    assign dec_ready = !full;
    assign enqueue   = dec_valid && dec_ready;

    // Uses the registered resolved bit, so a same-cycle resolve of the head retires next cycle.
    assign retire_kind = classify_retire(valid[head_idx] && resolved[head_idx],
                                         pred[head_idx], taken[head_idx]);
    assign retire      = (retire_kind != RET_NONE);
    assign squash      = (retire_kind == RET_MISPREDICT);

    buq_tag_match #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_tag_match (
        .alu_valid (alu_valid),
        .alu_tag   (alu_tag),
        .tags      (tags),
        .valid     (valid),
        .resolved  (resolved),
        .match     (match)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            valid    <= '0;
            resolved <= '0;
            taken    <= '0;
            pred     <= '0;
            addr     <= '0;
            tags     <= '0;
        end else if (squash) begin
            // Everything younger is wrong-path, including this cycle's enqueue and resolve.
            head     <= '0;
            tail     <= '0;
            valid    <= '0;
            resolved <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (match[i]) begin
                    resolved[i] <= 1'b1;
                    taken[i]    <= alu_taken;
                end
            end
            if (retire) begin
                valid[head_idx] <= 1'b0;
                head            <= head + PTR_W'(1);
            end
            if (enqueue) begin
                valid[tail_idx]    <= 1'b1;
                resolved[tail_idx] <= 1'b0;
                taken[tail_idx]    <= 1'b0;
                pred[tail_idx]     <= dec_prediction;
                addr[tail_idx]     <= dec_addr;
                tags[tail_idx]     <= dec_tag;
                tail               <= tail + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            brp_update     <= 1'b0;
            rob_addr       <= '0;
            rob_prediction <= 1'b0;
            mispredict     <= 1'b0;
            mispredict_tag <= '0;
        end else begin
            brp_update <= retire;
            mispredict <= squash;
            if (retire) begin
                rob_addr       <= addr[head_idx];
                rob_prediction <= taken[head_idx];
            end
            if (squash)
                mispredict_tag <= tags[head_idx];
        end
    end

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed and random checks of branch_update_queue against a queue-based program-order model.
module tb_branch_update_queue;

    localparam int ADDR_W = 6;
    localparam int TAG_W  = 3;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              dec_valid;
    logic [ADDR_W-1:0] dec_addr;
    logic              dec_prediction;
    logic [TAG_W-1:0]  dec_tag;
    logic              dec_ready;
    logic              alu_valid;
    logic [TAG_W-1:0]  alu_tag;
    logic              alu_taken;
    logic              brp_update;
    logic [ADDR_W-1:0] rob_addr;
    logic              rob_prediction;
    logic              mispredict;
    logic [TAG_W-1:0]  mispredict_tag;

    branch_update_queue #(
        .ADDR_W (ADDR_W),
        .TAG_W  (TAG_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dec_valid      (dec_valid),
        .dec_addr       (dec_addr),
        .dec_prediction (dec_prediction),
        .dec_tag        (dec_tag),
        .dec_ready      (dec_ready),
        .alu_valid      (alu_valid),
        .alu_tag        (alu_tag),
        .alu_taken      (alu_taken),
        .brp_update     (brp_update),
        .rob_addr       (rob_addr),
        .rob_prediction (rob_prediction),
        .mispredict     (mispredict),
        .mispredict_tag (mispredict_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        bit                pred;
        logic [TAG_W-1:0]  tag;
        bit                resolved;
        bit                taken;
    } entry_t;

    entry_t q[$];
    int checks  = 0;
    int passed  = 0;
    int n_strobe = 0;
    int n_mis    = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    function automatic bit tag_in_q(input logic [TAG_W-1:0] t);
        foreach (q[i])
            if (q[i].tag == t) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive inputs, predict from the model, clock, then compare and advance the model.
    task automatic step(input bit dv, input logic [ADDR_W-1:0] da, input bit dp,
                        input logic [TAG_W-1:0] dt, input bit av,
                        input logic [TAG_W-1:0] at, input bit ak);
        bit exp_ready, ret, mis;
        entry_t h;
        dec_valid      = dv;
        dec_addr       = da;
        dec_prediction = dp;
        dec_tag        = dt;
        alu_valid      = av;
        alu_tag        = at;
        alu_taken      = ak;
        exp_ready = (q.size() < DEPTH);
        ret = (q.size() > 0) && q[0].resolved;
        mis = ret && (q[0].taken != q[0].pred);
        if (ret) h = q[0];
        check("dec_ready", dec_ready, exp_ready);
        @(posedge clk);
        #1;
        if (mis) begin
            q.delete();
        end else begin
            if (ret) void'(q.pop_front());
            if (av)
                foreach (q[i])
                    if (q[i].tag == at && !q[i].resolved) begin
                        q[i].resolved = 1'b1;
                        q[i].taken    = ak;
                    end
            if (dv && exp_ready)
                q.push_back('{addr: da, pred: dp, tag: dt, resolved: 1'b0, taken: 1'b0});
        end
        check("brp_update", brp_update, ret);
        check("mispredict", mispredict, mis);
        if (ret) begin
            check("rob_addr", rob_addr, h.addr);
            check("rob_prediction", rob_prediction, h.taken);
        end
        if (mis) check("mispredict_tag", mispredict_tag, h.tag);
        if (brp_update === 1'b1) n_strobe++;
        if (mispredict === 1'b1) n_mis++;
        dec_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int s0, m0;
        bit dv, dp, av, ak;
        logic [ADDR_W-1:0] da;
        logic [TAG_W-1:0] dt, at;

        rst = 1'b0;
        dec_valid = 0; dec_addr = 0; dec_prediction = 0; dec_tag = 0;
        alu_valid = 0; alu_tag = 0; alu_taken = 0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_brp_update", brp_update, 0);
        check("rst_rob_addr", rob_addr, 0);
        check("rst_rob_prediction", rob_prediction, 0);
        check("rst_mispredict", mispredict, 0);
        check("rst_mispredict_tag", mispredict_tag, 0);
        check("rst_dec_ready", dec_ready, 1);
        rst = 1'b1;

        // single correct branch
        s0 = n_strobe;
        step(1, 5, 1, 2, 0, 0, 0);
        step(0, 0, 0, 0, 1, 2, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        check("single_rob_addr", rob_addr, 5);
        check("single_rob_prediction", rob_prediction, 1);
        idle(2);
        check("single_strobe_count", n_strobe - s0, 1);

        // out-of-order resolution
        s0 = n_strobe;
        step(1, 10, 1, 0, 0, 0, 0);
        step(1, 11, 0, 1, 0, 0, 0);
        step(1, 12, 1, 2, 0, 0, 0);
        step(0, 0, 0, 0, 1, 2, 1);
        idle(3);
        check("ooo_no_early_strobe", n_strobe - s0, 0);
        step(0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1, 1, 0);
        idle(4);
        check("ooo_strobe_count", n_strobe - s0, 3);

        // mispredict squash, with a wrong-path enqueue and resolve in the squash cycle
        s0 = n_strobe; m0 = n_mis;
        step(1, 20, 0, 3, 0, 0, 0);
        step(1, 21, 1, 4, 0, 0, 0);
        step(1, 22, 0, 5, 0, 0, 0);
        step(0, 0, 0, 0, 1, 4, 1);
        step(0, 0, 0, 0, 1, 3, 1);
        step(1, 23, 1, 6, 1, 5, 0);
        check("squash_mispredict_tag", mispredict_tag, 3);
        idle(4);
        check("squash_strobe_count", n_strobe - s0, 1);
        check("squash_mis_count", n_mis - m0, 1);
        check("squash_dec_ready", dec_ready, 1);
        step(0, 0, 0, 0, 1, 6, 1);
        idle(2);

        // full boundary with tail wrap
        step(1, 30, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 1);
        idle(2);
        for (int i = 0; i < DEPTH; i++) step(1, ADDR_W'(40 + i), 1, TAG_W'(i), 0, 0, 0);
        check("full_dec_ready", dec_ready, 0);
        step(1, 60, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 1);
        step(1, 61, 1, 0, 0, 0, 0);
        check("after_retire_dec_ready", dec_ready, 1);
        for (int i = 1; i < DEPTH; i++) step(0, 0, 0, 0, 1, TAG_W'(i), 1);
        idle(4);

        // async reset mid-stream with a resolved head pending
        for (int i = 1; i <= 4; i++) step(1, ADDR_W'(50 + i), 1, TAG_W'(i), 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 1);
        rst = 1'b0;
        #1;
        check("async_rst_dec_ready", dec_ready, 1);
        check("async_rst_brp_update", brp_update, 0);
        q.delete();
        #2 rst = 1'b1;
        s0 = n_strobe;
        idle(4);
        check("post_rst_no_strobe", n_strobe - s0, 0);

        // random traffic against the model
        for (int k = 0; k < 400; k++) begin
            dv = ($urandom_range(0, 9) < 6);
            da = ADDR_W'($urandom_range(0, 63));
            dp = 1'($urandom_range(0, 1));
            dt = TAG_W'($urandom_range(0, 7));
            if (q.size() < DEPTH)
                while (tag_in_q(dt)) dt = TAG_W'($urandom_range(0, 7));
            av = 1'($urandom_range(0, 1));
            ak = 1'($urandom_range(0, 1));
            at = TAG_W'($urandom_range(0, 7));
            if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
                int j;
                j  = $urandom_range(0, q.size() - 1);
                at = q[j].tag;
                ak = ($urandom_range(0, 4) == 0) ? !q[j].pred : q[j].pred;
            end
            step(dv, da, dp, dt, av, at, ak);
        end
        idle(12);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
